logs_pwm_mixer: RTL and testbench

Parametrised successor to the single-line audio mixer. It mixes N one-bit audio lines, each with its own runtime gain, into a saturated K-bit level. That level drives the single audio output in one of two modes: period-latched PWM or first-order sigma-delta. It sits between the voice generators and the output pin, and gains are written by the control logic through a simple write port.

---
 rtl/logs_pkg.sv | 13 +
 rtl/logs_sum.sv | 21 ++
 rtl/logs_pwm_mixer.sv | 143 ++++++++++++++
 tb/tb_logs_pwm_mixer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logs_pkg.sv
// Shared definitions for the logs audio blocks.
//   MODE_PWM / MODE_SD : encodings of the output modulator mode bit
//   sum_width(n, g)    : width of a sum of n gains of g bits that can never wrap
package logs_pkg;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    function automatic int unsigned sum_width(input int unsigned n, input int unsigned g);
        return g + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/logs_sum.sv
// Combinational sum of NADDENDS unsigned NBITS-wide addends.
// Ports:
//   addends : packed addends, addend i at [i*NBITS +: NBITS]
//   sum_c   : NBITS-wide sum; the caller sizes NBITS so it cannot wrap
module logs_sum #(
    parameter int unsigned NBITS    = 8,
    parameter int unsigned NADDENDS = 2
) (
    input  logic [NADDENDS*NBITS-1:0] addends,
    output logic [NBITS-1:0]          sum_c
);

    // Plain accumulation; synthesis is free to rebalance it into a tree.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NADDENDS; i++) begin
            sum_c = sum_c + addends[i*NBITS +: NBITS];
        end
    end

endmodule

// File: rtl/logs_pwm_mixer.sv
// N-line weighted audio mixer with PWM or sigma-delta 1-bit output.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   audio_in      : N one-bit audio lines, sampled every clk
//   gain_we/sel/data : per-channel gain write port (sel >= N ignored)
//   mode          : 0 = PWM, 1 = sigma-delta; taken only at period boundary
//   audio_out     : registered 1-bit mixed output
//   period_start  : registered pulse, high while the period counter is 0
//   clip          : registered, high while the registered sum exceeds 2^K-1
module logs_pwm_mixer
    import logs_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned G = 4,
    parameter int unsigned K = 5
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [N-1:0]                        audio_in,
    input  logic                                gain_we,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] gain_sel,
    input  logic [G-1:0]                        gain_data,
    input  logic                                mode,
    output logic                                audio_out,
    output logic                                period_start,
    output logic                                clip
);

    localparam int unsigned SW   = sum_width(N, G);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW   = (SW > K) ? SW : K;

    localparam logic [K-1:0] LVL_MAX  = '1;
    localparam logic [G-1:0] GAIN_RST = '1;

    logic [G-1:0]    gain_q [N];
    logic [G-1:0]    gain_d [N];
    logic [SW-1:0]   sum_r_q, sum_r_d;
    logic            clip_q, clip_d;
    logic [K-1:0]    cnt_q, cnt_d;
    logic            period_start_q, period_start_d;
    logic [K-1:0]    duty_q, duty_d;
    logic            mode_r_q, mode_r_d;
    logic [K-1:0]    acc_q, acc_d;
    logic            audio_out_q, audio_out_d;

    logic [N*SW-1:0] addends;
    logic [SW-1:0]   sum_c;
    logic [K-1:0]    lvl_c;
    logic            boundary_c;
    logic            acc_clr_c;
    logic [K-1:0]    acc_base_c;
    logic [K:0]      sd_sum_c;

    // Gain register file; out-of-range channel indices are dropped.
    always_comb begin
        gain_d = gain_q;
        if (gain_we && (32'(gain_sel) < N)) begin
            gain_d[gain_sel] = gain_data;
        end
    end

    // Each active line contributes its gain, zero-extended to the sum width.
    always_comb begin
        addends = '0;
        for (int unsigned i = 0; i < N; i++) begin
            addends[i*SW +: SW] = audio_in[i] ? SW'(gain_q[i]) : '0;
        end
    end

    logs_sum #(
        .NBITS    (SW),
        .NADDENDS (N)
    ) u_sum (
        .addends (addends),
        .sum_c   (sum_c)
    );

    // Stage 1 register inputs and the saturated level seen by the modulator.
    always_comb begin
        sum_r_d = sum_c;
        clip_d  = CW'(sum_c) > CW'(LVL_MAX);
        lvl_c   = (CW'(sum_r_q) > CW'(LVL_MAX)) ? LVL_MAX : K'(sum_r_q);
    end

    // Period counter, boundary latching and output modulator.
    always_comb begin
        cnt_d          = cnt_q + K'(1);
        boundary_c     = (cnt_q == LVL_MAX);
        period_start_d = (cnt_d == '0);
        duty_d         = duty_q;
        mode_r_d       = mode_r_q;
        acc_clr_c      = 1'b0;
        if (boundary_c) begin
            duty_d    = lvl_c;
            mode_r_d  = mode;
            acc_clr_c = (mode != mode_r_q);
        end
        // A mode change at the boundary starts the new period from a clean accumulator.
        acc_base_c = acc_clr_c ? '0 : acc_q;
        sd_sum_c   = {1'b0, acc_base_c} + {1'b0, lvl_c};
        // Output is computed for the next cycle's counter/duty/mode so that
        // PWM is high exactly while counter < duty.
        if (mode_r_d == MODE_SD) begin
            acc_d       = sd_sum_c[K-1:0];
            audio_out_d = sd_sum_c[K];
        end else begin
            acc_d       = acc_base_c;
            audio_out_d = (cnt_d < duty_d);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                gain_q[i] <= GAIN_RST;
            end
            sum_r_q        <= '0;
            clip_q         <= 1'b0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            duty_q         <= '0;
            mode_r_q       <= MODE_PWM;
            acc_q          <= '0;
            audio_out_q    <= 1'b0;
        end else begin
            gain_q         <= gain_d;
            sum_r_q        <= sum_r_d;
            clip_q         <= clip_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
            duty_q         <= duty_d;
            mode_r_q       <= mode_r_d;
            acc_q          <= acc_d;
            audio_out_q    <= audio_out_d;
        end
    end

    assign audio_out    = audio_out_q;
    assign period_start = period_start_q;
    assign clip         = clip_q;

endmodule

// File: tb/tb_logs_pwm_mixer.sv
// Scoreboard bench for logs_pwm_mixer: stimulus pushes point expectations
// (cycle, signal, value) and per-period pattern expectations; one monitor
// process samples on the falling edge and compares.
module tb_logs_pwm_mixer;

    localparam int unsigned N  = 4;
    localparam int unsigned G  = 4;
    localparam int unsigned K  = 5;
    localparam int unsigned N6 = 6;

    localparam int SIG_OUT  = 0;
    localparam int SIG_PS   = 1;
    localparam int SIG_CLIP = 2;
    localparam int SIG_SUM  = 3;
    localparam int SIG_SUM6 = 4;
    localparam int SIG_CLIP6 = 5;

    localparam int CYC_LIMIT = 2000;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } pt_t;

    typedef struct {
        int          start;
        logic [31:0] pat;
    } win_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] audio_in = '0;
    logic         gain_we = 1'b0;
    logic [1:0]   gain_sel = '0;
    logic [G-1:0] gain_data = '0;
    logic         mode = 1'b0;
    logic         audio_out, period_start, clip;

    logic [N6-1:0] audio_in6 = '0;
    logic          gain_we6 = 1'b0;
    logic [2:0]    gain_sel6 = '0;
    logic [G-1:0]  gain_data6 = '0;
    logic          audio_out6, period_start6, clip6;

    logs_pwm_mixer #(.N(N), .G(G), .K(K)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_in     (audio_in),
        .gain_we      (gain_we),
        .gain_sel     (gain_sel),
        .gain_data    (gain_data),
        .mode         (mode),
        .audio_out    (audio_out),
        .period_start (period_start),
        .clip         (clip)
    );

    logs_pwm_mixer #(.N(N6), .G(G), .K(K)) dut6 (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_in     (audio_in6),
        .gain_we      (gain_we6),
        .gain_sel     (gain_sel6),
        .gain_data    (gain_data6),
        .mode         (1'b0),
        .audio_out    (audio_out6),
        .period_start (period_start6),
        .clip         (clip6)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pt_t  pq[$];
    win_t wq[$];
    bit   done = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    function automatic string sig_name(input int s);
        case (s)
            SIG_OUT:   return "audio_out";
            SIG_PS:    return "period_start";
            SIG_CLIP:  return "clip";
            SIG_SUM:   return "sum_r";
            SIG_SUM6:  return "sum_r(N=6)";
            default:   return "clip(N=6)";
        endcase
    endfunction

    function automatic int sample(input int s);
        case (s)
            SIG_OUT:   return int'(audio_out);
            SIG_PS:    return int'(period_start);
            SIG_CLIP:  return int'(clip);
            SIG_SUM:   return int'(dut.sum_r_q);
            SIG_SUM6:  return int'(dut6.sum_r_q);
            default:   return int'(clip6);
        endcase
    endfunction

    function automatic void exp_pt(input int c, input int s, input int v);
        pt_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        pq.push_back(e);
    endfunction

    function automatic void exp_win(input int start, input logic [31:0] pat);
        win_t e;
        e.start = start;
        e.pat   = pat;
        wq.push_back(e);
    endfunction

    // Monitor: point checks, period-window checks, end of run.
    bit          in_win = 1'b0;
    int          win_start = 0;
    int          win_idx = 0;
    logic [31:0] win_pat = '0;
    bit          ended = 1'b0;

    always @(negedge clk) begin : monitor
        int act;
        if (!ended) begin
            for (int i = pq.size() - 1; i >= 0; i--) begin
                if (pq[i].cyc == cyc) begin
                    act = sample(pq[i].sig);
                    n_chk++;
                    if (act != pq[i].val) begin
                        n_fail++;
                        $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                                 sig_name(pq[i].sig), cyc, act, pq[i].val);
                    end
                    pq.delete(i);
                end else if (pq[i].cyc < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL %s @cyc %0d: expected %0d but cycle was never sampled",
                             sig_name(pq[i].sig), pq[i].cyc, pq[i].val);
                    pq.delete(i);
                end
            end

            if (!reset_n) begin
                in_win = 1'b0;
            end else begin
                if (period_start) begin
                    if (in_win) begin
                        while (wq.size() > 0 && wq[0].start < win_start) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL period@%0d: no period observed, expected pattern %h",
                                     wq[0].start, wq[0].pat);
                            void'(wq.pop_front());
                        end
                        if (wq.size() > 0 && wq[0].start == win_start) begin
                            n_chk++;
                            if (win_idx != 32 || win_pat != wq[0].pat) begin
                                n_fail++;
                                $display("FAIL period@%0d: got pattern %h (len %0d), expected %h (len 32)",
                                         win_start, win_pat, win_idx, wq[0].pat);
                            end
                            void'(wq.pop_front());
                        end
                    end
                    in_win    = 1'b1;
                    win_start = cyc;
                    win_idx   = 0;
                    win_pat   = '0;
                end
                if (in_win) begin
                    if (win_idx < 32) win_pat[win_idx] = audio_out;
                    win_idx++;
                end
            end

            if (done || cyc > CYC_LIMIT) begin
                if (!done) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL timeout: stimulus not complete by cycle %0d", CYC_LIMIT);
                end
                foreach (pq[i]) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL %s @cyc %0d: expectation left unchecked", sig_name(pq[i].sig), pq[i].cyc);
                end
                foreach (wq[i]) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL period@%0d: expectation left unchecked", wq[i].start);
                end
                ended = 1'b1;
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) step();
    endtask

    // Stimulus: every action happens just after the posedge that ends cycle c.
    initial begin : stim
        int r0;
        int r;

        // Saturating run, then asynchronous reset while audio_out is high.
        at(3);
        r0 = cyc;
        reset_n  = 1'b1;
        audio_in = 4'b1111;
        exp_pt(r0 + 39, SIG_OUT, 1);
        exp_pt(r0 + 39, SIG_CLIP, 1);
        exp_pt(r0 + 40, SIG_OUT, 0);
        exp_pt(r0 + 40, SIG_CLIP, 0);
        exp_pt(r0 + 40, SIG_PS, 0);
        exp_pt(r0 + 42, SIG_SUM, 0);
        at(r0 + 40);
        reset_n  = 1'b0;
        audio_in = '0;
        at(r0 + 43);
        reset_n = 1'b1;
        r = cyc;

        // Idle after release: output low, period_start at +32 and +64.
        for (int k = 1; k <= 64; k++) begin
            exp_pt(r + k, SIG_OUT, 0);
            exp_pt(r + k, SIG_PS, (k % 32 == 0) ? 1 : 0);
        end
        exp_pt(r + 64, SIG_CLIP, 0);

        // Wide instance: channel 5 writable, indices 6 and 7 ignored.
        exp_pt(r + 4, SIG_SUM6, 0);
        exp_pt(r + 5, SIG_SUM6, 82);
        exp_pt(r + 5, SIG_CLIP6, 1);
        exp_pt(r + 6, SIG_SUM6, 7);
        exp_pt(r + 6, SIG_CLIP6, 0);

        // Saturation with reset-default gains (15 each).
        exp_pt(r + 65, SIG_CLIP, 1);
        exp_pt(r + 65, SIG_SUM, 60);
        exp_win(r + 64, 32'h0000_0000);
        exp_win(r + 96, 32'h7FFF_FFFF);
        exp_win(r + 128, 32'h7FFF_FFFF);
        exp_pt(r + 140, SIG_CLIP, 1);
        exp_pt(r + 141, SIG_CLIP, 0);
        exp_win(r + 160, 32'h0000_0000);

        // Gain write coinciding with the line going active.
        exp_pt(r + 162, SIG_SUM, 15);
        exp_pt(r + 162, SIG_CLIP, 0);
        exp_pt(r + 163, SIG_SUM, 5);

        // PWM duty 3; gain[3] must stay 0 despite the unstrobed data.
        exp_pt(r + 170, SIG_SUM, 3);
        exp_win(r + 192, 32'h0000_0007);
        exp_win(r + 224, 32'h0000_0007);

        // Level 10 -> 20 at counter 7.
        exp_pt(r + 233, SIG_SUM, 10);
        exp_win(r + 256, 32'h0000_03FF);
        exp_pt(r + 262, SIG_SUM, 10);
        exp_pt(r + 263, SIG_SUM, 20);
        exp_win(r + 288, 32'h000F_FFFF);

        // Sigma-delta at level 8, then back to PWM.
        exp_pt(r + 292, SIG_SUM, 8);
        exp_win(r + 320, 32'h8888_8888);
        exp_win(r + 352, 32'h8888_8888);
        exp_win(r + 384, 32'h0000_00FF);

        at(r + 1);
        gain_we6 = 1'b1; gain_sel6 = 3'd5; gain_data6 = 4'd7;
        at(r + 2);
        gain_sel6 = 3'd6; gain_data6 = 4'd0;
        at(r + 3);
        gain_sel6 = 3'd7; gain_data6 = 4'd0;
        at(r + 4);
        gain_we6 = 1'b0; audio_in6 = 6'b111111;
        at(r + 5);
        audio_in6 = 6'b100000;

        at(r + 64);
        audio_in = 4'b1111;
        at(r + 140);
        audio_in = 4'b0000;

        at(r + 161);
        audio_in = 4'b0100; gain_we = 1'b1; gain_sel = 2'd2; gain_data = 4'd5;
        at(r + 162);
        gain_we = 1'b0;
        at(r + 163);
        audio_in = 4'b0000;

        at(r + 164);
        gain_we = 1'b1; gain_sel = 2'd0; gain_data = 4'd3;
        at(r + 165);
        gain_sel = 2'd1; gain_data = 4'd0;
        at(r + 166);
        gain_sel = 2'd2; gain_data = 4'd0;
        at(r + 167);
        gain_sel = 2'd3; gain_data = 4'd0;
        at(r + 168);
        gain_we = 1'b0; gain_sel = 2'd3; gain_data = 4'd9;
        at(r + 169);
        audio_in = 4'b1001;

        at(r + 230);
        gain_we = 1'b1; gain_sel = 2'd1; gain_data = 4'd10;
        at(r + 231);
        gain_sel = 2'd2; gain_data = 4'd10;
        at(r + 232);
        gain_we = 1'b0; audio_in = 4'b0010;
        at(r + 262);
        audio_in = 4'b0110;

        at(r + 290);
        gain_we = 1'b1; gain_sel = 2'd1; gain_data = 4'd8;
        at(r + 291);
        gain_we = 1'b0; audio_in = 4'b0010;
        at(r + 300);
        mode = 1'b1;
        at(r + 360);
        mode = 1'b0;

        at(r + 420);
        done = 1'b1;
    end

endmodule
